// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the radix-2 SDF FFT output.
// Two banks of 2^N complex words ping-pong so back-to-back frames stream without gaps.
module bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_ip,
  input  logic signed [W-1:0] ip_re,
  input  logic signed [W-1:0] ip_im,
  output logic signed [W-1:0] op_re,
  output logic signed [W-1:0] op_im,
  output logic                op_valid,
  output logic                start_op
);

  localparam int L = 1 << N;
  localparam logic [N-1:0] LAST = {N{1'b1}};

  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_t;

  wr_state_t      wr_state_reg;
  rd_state_t      rd_state_reg;
  logic [N-1:0]   wr_cnt_reg;
  logic [N-1:0]   rd_cnt_reg;
  logic           wr_bank_reg;
  logic           rd_bank_reg;

  logic [2*W-1:0] mem [0:2*L-1];

  logic           wr_en;
  logic           wr_last;
  logic [N-1:0]   wr_k;
  logic [N-1:0]   wr_addr;

  // start_ip forces k=0 in any state, which also covers mid-frame restarts.
  assign wr_en   = !rst && (start_ip || (wr_state_reg == WR_ACTIVE));
  assign wr_k    = start_ip ? '0 : wr_cnt_reg;
  assign wr_last = wr_en && (wr_k == LAST);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bitrev
      assign wr_addr[gi] = wr_k[N-1-gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_reg, wr_addr}] <= {ip_re, ip_im};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg <= WR_IDLE;
      wr_cnt_reg   <= '0;
      wr_bank_reg  <= 1'b0;
      rd_state_reg <= RD_IDLE;
      rd_cnt_reg   <= '0;
      rd_bank_reg  <= 1'b0;
    end else begin
      if (wr_last) begin
        wr_state_reg <= WR_IDLE;
        wr_cnt_reg   <= '0;
        wr_bank_reg  <= ~wr_bank_reg;
      end else if (wr_en) begin
        wr_state_reg <= WR_ACTIVE;
        wr_cnt_reg   <= wr_k + 1'b1;
      end

      // A completed bank takes priority so a read finishing this cycle rolls straight on.
      if (wr_last) begin
        rd_state_reg <= RD_ACTIVE;
        rd_cnt_reg   <= '0;
        rd_bank_reg  <= wr_bank_reg;
      end else if (rd_state_reg == RD_ACTIVE) begin
        if (rd_cnt_reg == LAST) begin
          rd_state_reg <= RD_IDLE;
          rd_cnt_reg   <= '0;
        end else begin
          rd_cnt_reg <= rd_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Registered read doubles as the output register; it is forced to zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_re    <= '0;
      op_im    <= '0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
    end else if (rd_state_reg == RD_ACTIVE) begin
      {op_re, op_im} <= mem[{rd_bank_reg, rd_cnt_reg}];
      op_valid       <= 1'b1;
      start_op       <= (rd_cnt_reg == '0);
    end else begin
      op_re    <= '0;
      op_im    <= '0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
    end
  end

endmodule
